// File: rtl/if_id_pkg.sv
// if_id_pkg: shared definitions for the IF/ID interstage buffer.
//   XLEN           default datapath width of PC, instruction and PC+4
//   NOP_INST       bubble instruction shown to decode when the buffer is empty
//   fetch_bundle_t one fetched bundle {pc, inst, pc4}
package if_id_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc4;
    } fetch_bundle_t;

endpackage

// File: rtl/if_id_buffer.sv
// if_id_buffer: elastic FIFO between fetch and decode.
//   clk, reset            clock, asynchronous active-low reset
//   if_valid/if_ready     fetch-side handshake; if_ready doubles as the fetch PC enable
//   if_pc/if_inst/if_pc4  incoming bundle
//   flush                 stage-4 redirect; drops queued and incoming bundles
//   id_valid/id_ready     decode-side handshake
//   id_pc/id_inst/id_pc4  head bundle, or a NOP bubble when empty
//   count                 number of occupied entries
module if_id_buffer
    import if_id_pkg::*;
#(
    parameter int unsigned XLEN  = if_id_pkg::XLEN,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     if_valid,
    output logic                     if_ready,
    input  logic [XLEN-1:0]          if_pc,
    input  logic [XLEN-1:0]          if_inst,
    input  logic [XLEN-1:0]          if_pc4,
    input  logic                     flush,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [XLEN-1:0]          id_pc,
    output logic [XLEN-1:0]          id_inst,
    output logic [XLEN-1:0]          id_pc4,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc4;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;

    // Ready comes only from registered occupancy: a pop this cycle never frees a slot.
    assign if_ready = (count_q != CW'(DEPTH));
    assign id_valid = (count_q != '0);
    assign count    = count_q;

    assign push = if_valid & if_ready & ~flush;
    assign pop  = id_valid & id_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage holds no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= '{pc: if_pc, inst: if_inst, pc4: if_pc4};
        end
    end

    always_comb begin
        id_pc   = '0;
        id_inst = XLEN'(NOP_INST);
        id_pc4  = '0;
        if (id_valid) begin
            id_pc   = mem[rd_ptr_q].pc;
            id_inst = mem[rd_ptr_q].inst;
            id_pc4  = mem[rd_ptr_q].pc4;
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;
    import if_id_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic              clk;
    logic              clk_en;
    logic              reset;
    logic              if_valid;
    logic              if_ready;
    logic [XLEN-1:0]   if_pc, if_inst, if_pc4;
    logic              flush;
    logic              id_valid;
    logic              id_ready;
    logic [XLEN-1:0]   id_pc, id_inst, id_pc4;
    logic [$clog2(DEPTH):0] count;

    int n_checks;
    int n_pass;

    fetch_bundle_t sb[$];

    if_id_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_pc4   (if_pc4),
        .flush    (flush),
        .id_valid (id_valid),
        .id_ready (id_ready),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_pc4   (id_pc4),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    // Compare all outputs against the scoreboard state.
    task automatic check_outputs(input string tag);
        check({tag, ".if_ready"}, 32'(if_ready), 32'(sb.size() != DEPTH));
        check({tag, ".id_valid"}, 32'(id_valid), 32'(sb.size() != 0));
        check({tag, ".count"}, 32'(count), 32'(sb.size()));
        if (sb.size() != 0) begin
            check({tag, ".id_pc"}, id_pc, sb[0].pc);
            check({tag, ".id_inst"}, id_inst, sb[0].inst);
            check({tag, ".id_pc4"}, id_pc4, sb[0].pc4);
        end else begin
            check({tag, ".id_pc"}, id_pc, 32'h0);
            check({tag, ".id_inst"}, id_inst, NOP_INST);
            check({tag, ".id_pc4"}, id_pc4, 32'h0);
        end
    endtask

    // One cycle: drive at negedge, check, update model, advance across the posedge.
    task automatic cycle(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] inst, input logic fl, input logic rdy);
        bit m_push, m_pop;
        fetch_bundle_t b;
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
        if_pc4   = pc + 32'd4;
        flush    = fl;
        id_ready = rdy;
        #1;
        check_outputs(tag);
        m_push = v && (sb.size() != DEPTH) && !fl;
        m_pop  = (sb.size() != 0) && rdy && !fl;
        if (fl) begin
            sb.delete();
        end else begin
            if (m_pop) void'(sb.pop_front());
            if (m_push) begin
                b.pc = pc; b.inst = inst; b.pc4 = pc + 32'd4;
                sb.push_back(b);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clk_en   = 1'b0;
        reset    = 1'b0;
        if_valid = 1'b0;
        if_pc    = '0;
        if_inst  = '0;
        if_pc4   = '0;
        flush    = 1'b1;  // flush during reset must not matter
        id_ready = 1'b1;

        // Reset with no clock running.
        #3;
        check("rst.count", 32'(count), 32'd0);
        check("rst.id_valid", 32'(id_valid), 32'd0);
        check("rst.id_inst", id_inst, 32'h0000_0013);
        check("rst.id_pc", id_pc, 32'h0);
        check("rst.if_ready", 32'(if_ready), 32'd1);
        flush = 1'b0;
        #2 reset = 1'b1;
        clk_en = 1'b1;
        @(negedge clk);

        // Streaming with decode always ready.
        cycle("str0", 1'b1, 32'h00, 32'hA0, 1'b0, 1'b1);
        cycle("str1", 1'b1, 32'h04, 32'hA1, 1'b0, 1'b1);
        cycle("str2", 1'b1, 32'h08, 32'hA2, 1'b0, 1'b1);
        cycle("str3", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        cycle("str4", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Full / backpressure.
        cycle("bp0", 1'b1, 32'h10, 32'hB0, 1'b0, 1'b0);
        cycle("bp1", 1'b1, 32'h14, 32'hB1, 1'b0, 1'b0);
        cycle("bp2", 1'b1, 32'h18, 32'hB2, 1'b0, 1'b0);  // full: held
        cycle("bp3", 1'b1, 32'h18, 32'hB2, 1'b0, 1'b1);  // pops 0x10, still not accepted
        cycle("bp4", 1'b1, 32'h18, 32'hB2, 1'b0, 1'b1);  // pops 0x14, accepts 0x18
        cycle("bp5", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        cycle("bp6", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Flush with simultaneous push and pop.
        cycle("fl0", 1'b1, 32'h30, 32'hC0, 1'b0, 1'b0);
        cycle("fl1", 1'b1, 32'h34, 32'hC1, 1'b0, 1'b0);
        cycle("fl2", 1'b1, 32'h40, 32'hC2, 1'b1, 1'b1);
        cycle("fl3", 1'b1, 32'h80, 32'hC3, 1'b0, 1'b0);
        cycle("fl4", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        cycle("fl5", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Wrap-around with random stalls on both sides.
        for (int i = 0; i < 40; i++) begin
            cycle("wrap", 1'($urandom_range(0, 3) != 0), 32'h200 + 32'(i * 4), $urandom,
                  1'b0, 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 3; i++) cycle("wrapdrain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Reset mid-operation, asserted between edges.
        cycle("mr0", 1'b1, 32'h50, 32'hD0, 1'b0, 1'b0);
        cycle("mr1", 1'b1, 32'h54, 32'hD1, 1'b0, 1'b0);
        check("mr.count_pre", 32'(count), 32'd2);
        #2 reset = 1'b0;
        #1;
        sb.delete();
        check("mr.count", 32'(count), 32'd0);
        check("mr.id_valid", 32'(id_valid), 32'd0);
        check("mr.if_ready", 32'(if_ready), 32'd1);
        check("mr.id_inst", id_inst, NOP_INST);
        @(negedge clk);
        reset = 1'b1;
        cycle("mr2", 1'b1, 32'h100, 32'hE0, 1'b0, 1'b0);
        cycle("mr3", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        cycle("mr4", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
